fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side drain engine for the dual-clock FIFO.
- Sits in the read clock domain. Watches the FIFO head (rdata/rempty) and issues rinc pops.
- Presents popped words on an AXI4-Stream master with registered outputs and a 2-entry skid buffer.
- Frames the stream into packets of a programmable beat count and asserts tlast on the final beat of each packet.

Parameters:
- DSIZE, 32, data width; must match the FIFO DSIZE.
- LSIZE, 16, width of the packet-length input and the beat counter.
- CSIZE, 32, width of the packet statistics counter (used only with the optional feature).

Ports:
- rclk  input  1  read-domain clock; the only clock.
- rrst_n  input  1  reset, synchronous, active-low, sampled on rising rclk.
- rdata  input  DSIZE  FIFO head word; valid whenever rempty=0 (first-word fall-through, combinational read).
- rempty  input  1  FIFO empty flag.
- rinc  output  1  FIFO pop strobe; one word is consumed per rclk cycle while high.
- pkt_len  input  LSIZE  beats per packet; 0 is treated as 1.
- m_axis_tdata  output  DSIZE  stream data.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready from downstream.
- m_axis_tlast  output  1  last beat of a packet.
- pkt_cnt  output  CSIZE  completed-packet count; present only with FIFO_RD_STREAM_STAT_EN.

Behaviour:
- Reset (rrst_n=0 at a rising rclk edge):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Buffer occupancy=0, beat counter=0, pkt_cnt=0.
  - rinc is forced 0 while rrst_n=0.
- Buffer: 2 entries (output register plus skid register). Each entry holds {data, last}. Occupancy states are EMPTY(0), ONE(1), TWO(2).
- Pop rule: rinc = rrst_n & ~rempty & (occupancy < 2). This is combinational from registered occupancy and rempty; it never depends on m_axis_tready.
- Load: when rinc=1, rdata is captured on the same edge.
  - If the output register will be free after this edge, the word goes to the output register. Free means EMPTY, or ONE with the output handshake completing this cycle.
  - Otherwise the word goes to the skid register.
- Handshake: a beat transfers when m_axis_tvalid & m_axis_tready at the rising edge. On transfer, the skid entry (if any) moves to the output register.
  - m_axis_tdata and m_axis_tlast hold stable while tvalid=1 and tready=0.
- Latency: a word present at the FIFO head (rempty=0) in cycle N with room in the buffer appears with m_axis_tvalid=1 in cycle N+1.
- Throughput: 1 beat per clock sustained when rempty=0 and tready=1 continuously.
- Occupancy transitions:
  - EMPTY→ONE on pop.
  - ONE→ONE on pop plus transfer.
  - ONE→TWO on pop without transfer.
  - ONE→EMPTY on transfer without pop.
  - TWO→ONE on transfer. No pop is possible in TWO.
- Framing: the beat counter counts words popped (not transferred).
  - pkt_len is sampled into a length register when a pop occurs with beat counter=0. A mid-packet change of pkt_len takes effect at the next packet.
  - last bit of the popped word = (beat counter == length-1), with length = max(pkt_len,1).
  - The counter increments on each pop and clears to 0 on the pop carrying last=1.
- Width rule: pkt_len=2^LSIZE-1 is legal. The counter never wraps within a packet.
- Simultaneous pop and transfer in ONE: the output register is overwritten with the new word; no bubble and no loss.
- rempty rising while the buffer is non-empty: already-buffered words still drain normally.
- Reset mid-operation: buffered words and any partial packet are discarded (not delivered). The next packet starts at beat 0.

Optional Feature:
- Macro: FIFO_RD_STREAM_STAT_EN.
- Defined:
  - The pkt_cnt port exists.
  - pkt_cnt increments by 1 on every transfer with m_axis_tlast=1.
  - It wraps modulo 2^CSIZE and is reset to 0.
- Undefined: the pkt_cnt port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rrst_n=0 for 3 cycles with rempty=0 → rinc=0, tvalid=0, tdata=0, tlast=0. In the first cycle after release, rinc=1.
- Streaming: 8 words 0x0..0x7 at the FIFO head, pkt_len=4, tready=1 → 8 consecutive beats starting 1 cycle after the first rinc. tlast=1 on data 0x3 and 0x7. pkt_cnt=2 with STAT_EN.
- Backpressure: tready=0 with words available → exactly 2 rinc pulses, then rinc=0. tdata is held at the first word. After tready=1, words are delivered in order with no loss or duplication.
- pkt_len=0 and pkt_len=1: 3 words → tlast=1 on every beat in both cases.
- Mid-packet pkt_len change from 3 to 2 after beat 1 → the first packet is still 3 beats, and subsequent packets are 2 beats.
- Reset mid-packet: after 2 of 4 beats, with 2 words buffered and tready=0, pulse rrst_n=0 → tvalid=0. The next delivered packet's tlast lands on its 4th beat.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side drain engine for the dual-clock FIFO. Lives entirely in the read
// clock domain. It pops words from a first-word-fall-through FIFO head and
// presents them on an AXI4-Stream master. A 2-entry buffer (output register
// plus skid register) sits between the FIFO and the stream. Words are framed
// into packets of pkt_len beats, and m_axis_tlast marks the final beat.
//
// Optional feature macro: FIFO_RD_STREAM_STAT_EN
//   When defined, the pkt_cnt output exists. It counts completed packets,
//   meaning transfers with tlast=1, and wraps modulo 2^CSIZE.
//
// Ports:
//   rclk           in   read-domain clock (only clock)
//   rrst_n         in   synchronous active-low reset
//   rdata          in   FIFO head word, valid while rempty=0
//   rempty         in   FIFO empty flag
//   rinc           out  FIFO pop strobe, one word per cycle while high
//   pkt_len        in   beats per packet (0 behaves as 1)
//   m_axis_tdata   out  stream data
//   m_axis_tvalid  out  stream valid
//   m_axis_tready  in   stream ready
//   m_axis_tlast   out  last beat of packet
//   pkt_cnt        out  completed-packet count (FIFO_RD_STREAM_STAT_EN only)
//
// Handshake: a beat moves when m_axis_tvalid and m_axis_tready are both high
// at a rising rclk edge. While tvalid=1 and tready=0, tdata and tlast hold.
// tvalid never depends on tready. The FIFO side pops whenever the buffer has
// room, independent of tready.
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DSIZE = 32,
    parameter int LSIZE = 16,
    parameter int CSIZE = 32
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic [LSIZE-1:0] pkt_len,
    output logic [DSIZE-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
`ifdef FIFO_RD_STREAM_STAT_EN
    ,
    output logic [CSIZE-1:0] pkt_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_t;

    occ_t             r_occ;
    occ_t             w_occ_nxt;

    logic [DSIZE-1:0] r_out_data;
    logic             r_out_last;
    logic [DSIZE-1:0] r_skid_data;
    logic             r_skid_last;
    logic [LSIZE-1:0] r_beat;
    logic [LSIZE-1:0] r_len;

    logic             w_pop;
    logic             w_xfer;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_skid_to_out;
    logic [LSIZE-1:0] w_len_new;
    logic [LSIZE-1:0] w_len_cur;
    logic             w_last;

    // Pop depends only on registered occupancy and rempty. It never depends
    // on tready, so no combinational path runs from downstream to the FIFO.
    assign w_pop  = rrst_n & ~rempty & (r_occ != S_TWO);
    assign rinc   = w_pop;

    assign w_xfer = (r_occ != S_EMPTY) & m_axis_tready;

    // The length is latched at the first pop of a packet. A pkt_len change
    // in mid-packet therefore only affects the next packet.
    assign w_len_new = (pkt_len == '0) ? LSIZE'(1) : pkt_len;
    assign w_len_cur = (r_beat == '0) ? w_len_new : r_len;
    assign w_last    = (r_beat == (w_len_cur - LSIZE'(1)));

    // The output register is free when it is empty, or when it holds one
    // word that leaves this cycle. In that case the new word overwrites it
    // directly, which gives 1 beat per clock with no bubble.
    assign w_load_out    = w_pop & ((r_occ == S_EMPTY) | ((r_occ == S_ONE) & w_xfer));
    assign w_load_skid   = w_pop & ~w_load_out;
    assign w_skid_to_out = (r_occ == S_TWO) & w_xfer;

    // Occupancy state register
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_occ <= S_EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    // Occupancy next-state
    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            S_EMPTY: begin
                if (w_pop) w_occ_nxt = S_ONE;
            end
            S_ONE: begin
                if (w_pop && !w_xfer)      w_occ_nxt = S_TWO;
                else if (!w_pop && w_xfer) w_occ_nxt = S_EMPTY;
            end
            S_TWO: begin
                if (w_xfer) w_occ_nxt = S_ONE;
            end
            default: w_occ_nxt = S_EMPTY;
        endcase
    end

    // Buffer datapath
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
        end else begin
            if (w_load_out) begin
                r_out_data <= rdata;
                r_out_last <= w_last;
            end else if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
                r_out_last <= r_skid_last;
            end
            if (w_load_skid) begin
                r_skid_data <= rdata;
                r_skid_last <= w_last;
            end
        end
    end

    // Beat counter counts pops, not transfers. The last bit is attached to
    // the word as it enters the buffer.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_beat <= '0;
            r_len  <= '0;
        end else if (w_pop) begin
            if (r_beat == '0) r_len <= w_len_new;
            if (w_last) r_beat <= '0;
            else        r_beat <= r_beat + LSIZE'(1);
        end
    end

    assign m_axis_tvalid = (r_occ != S_EMPTY);
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;

`ifdef FIFO_RD_STREAM_STAT_EN
    logic [CSIZE-1:0] r_pkt_cnt;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_pkt_cnt <= '0;
        end else if (w_xfer && r_out_last) begin
            r_pkt_cnt <= r_pkt_cnt + CSIZE'(1);
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Directed bench for fifo_rd_stream. A small FWFT FIFO model feeds the DUT.
// A sink records every transferred beat. Expected beats are hand-computed
// values pushed onto exp_q and compared in order against the recorded beats.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int DSIZE = 32;
    localparam int LSIZE = 16;
    localparam int CSIZE = 32;

    // ---------------- clock / reset ----------------
    logic             rclk   = 1'b0;
    logic             rrst_n = 1'b0;
    always #5 rclk = ~rclk;

    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic [LSIZE-1:0] pkt_len = '0;
    logic [DSIZE-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic             m_axis_tlast;
`ifdef FIFO_RD_STREAM_STAT_EN
    logic [CSIZE-1:0] pkt_cnt;
`endif

    fifo_rd_stream #(.DSIZE(DSIZE), .LSIZE(LSIZE), .CSIZE(CSIZE)) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rdata         (rdata),
        .rempty        (rempty),
        .rinc          (rinc),
        .pkt_len       (pkt_len),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
`ifdef FIFO_RD_STREAM_STAT_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    // ---------------- FWFT source FIFO model ----------------
    logic [DSIZE-1:0] src_mem [0:255];
    int               src_wr = 0;
    int               src_rd = 0;

    assign rempty = (src_rd == src_wr);
    assign rdata  = src_mem[src_rd[7:0]];

    always @(posedge rclk) begin
        if (rinc) src_rd <= src_rd + 1;
    end

    // ---------------- sink recorder ----------------
    logic [DSIZE:0] got_mem [0:255];
    int             got_n = 0;

    always @(posedge rclk) begin
        if (rrst_n && m_axis_tvalid && m_axis_tready) begin
            got_mem[got_n[7:0]] <= {m_axis_tlast, m_axis_tdata};
            got_n <= got_n + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [DSIZE:0] exp_q[$];
    int             got_rd = 0;
    int             total  = 0;
    int             bad    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DSIZE-1:0] d);
        src_mem[src_wr[7:0]] = d;
        src_wr++;
    endtask

    task automatic expect_beat(input logic [DSIZE-1:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    // Waits (bounded) for all queued beats, then compares them in order.
    task automatic expect_beats(input string tag, input int budget);
        int waited;
        int need;
        waited = 0;
        need   = exp_q.size();
        while ((got_n - got_rd) < need && waited < budget) begin
            @(negedge rclk);
            waited++;
        end
        check({tag, "_timeout"}, 64'((got_n - got_rd) >= need), 64'd1);
        if ((got_n - got_rd) < need) begin
            exp_q.delete();
            got_rd = got_n;
        end else begin
            while (exp_q.size() > 0) begin
                check(tag, 64'(got_mem[got_rd[7:0]]), 64'(exp_q.pop_front()));
                got_rd++;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rinc_cnt;

        // Reset held 3 cycles with data waiting at the FIFO head
        rrst_n        = 1'b0;
        m_axis_tready = 1'b1;
        pkt_len       = 16'd4;
        for (int i = 0; i < 8; i++) push(DSIZE'(i));
        repeat (3) @(negedge rclk);
        check("rst_rinc",  64'(rinc), 64'd0);
        check("rst_valid", 64'(m_axis_tvalid), 64'd0);
        check("rst_data",  64'(m_axis_tdata), 64'd0);
        check("rst_last",  64'(m_axis_tlast), 64'd0);

        // Release: the pop is immediate, and valid follows one cycle later
        rrst_n = 1'b1;
        #1;
        check("rel_rinc",  64'(rinc), 64'd1);
        check("rel_valid", 64'(m_axis_tvalid), 64'd0);

        // Streaming: 8 back-to-back beats, with tlast on 3 and 7
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk);
            check("str_valid", 64'(m_axis_tvalid), 64'd1);
            check("str_data",  64'(m_axis_tdata), 64'(i));
            check("str_last",  64'(m_axis_tlast), 64'((i == 3) || (i == 7)));
        end
        @(negedge rclk);
        check("str_idle", 64'(m_axis_tvalid), 64'd0);
`ifdef FIFO_RD_STREAM_STAT_EN
        check("str_pktcnt", 64'(pkt_cnt), 64'd2);
`endif
        for (int i = 0; i < 8; i++) expect_beat(DSIZE'(i), (i == 3) || (i == 7));
        expect_beats("str_sb", 20);

        // Backpressure: only two pops fill the buffer, and the head word holds
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) push(DSIZE'(32'h10 + i));
        #1;
        rinc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (rinc) rinc_cnt++;
            @(negedge rclk);
        end
        check("bp_rinc_cnt", 64'(rinc_cnt), 64'd2);
        check("bp_rinc_now", 64'(rinc), 64'd0);
        check("bp_valid",    64'(m_axis_tvalid), 64'd1);
        check("bp_hold",     64'(m_axis_tdata), 64'h10);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) expect_beat(DSIZE'(32'h10 + i), (i == 3) || (i == 7));
        expect_beats("bp_sb", 40);

        // pkt_len = 0 behaves as 1
        pkt_len = 16'd0;
        for (int i = 0; i < 3; i++) push(DSIZE'(32'h20 + i));
        for (int i = 0; i < 3; i++) expect_beat(DSIZE'(32'h20 + i), 1'b1);
        expect_beats("len0_sb", 20);

        // pkt_len = 1
        pkt_len = 16'd1;
        for (int i = 0; i < 3; i++) push(DSIZE'(32'h30 + i));
        for (int i = 0; i < 3; i++) expect_beat(DSIZE'(32'h30 + i), 1'b1);
        expect_beats("len1_sb", 20);

        // Mid-packet length change 3 -> 2 after beat 1
        pkt_len = 16'd3;
        push(32'h40);
        push(32'h41);
        expect_beat(32'h40, 1'b0);
        expect_beat(32'h41, 1'b0);
        expect_beats("chg_a_sb", 20);
        pkt_len = 16'd2;
        for (int i = 2; i < 7; i++) push(DSIZE'(32'h40 + i));
        expect_beat(32'h42, 1'b1);
        expect_beat(32'h43, 1'b0);
        expect_beat(32'h44, 1'b1);
        expect_beat(32'h45, 1'b0);
        expect_beat(32'h46, 1'b1);
        expect_beats("chg_b_sb", 20);

        // Reset mid-packet: 2 of 4 beats delivered, 2 buffered, then reset
        pkt_len = 16'd4;
        push(32'h50);
        push(32'h51);
        expect_beat(32'h50, 1'b0);
        expect_beat(32'h51, 1'b0);
        expect_beats("mid_a_sb", 20);
        m_axis_tready = 1'b0;
        push(32'h52);
        push(32'h53);
        repeat (4) @(negedge rclk);
        check("mid_full_rinc", 64'(rinc), 64'd0);
        check("mid_full_data", 64'(m_axis_tdata), 64'h52);
        rrst_n = 1'b0;
        @(negedge rclk);
        check("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_data",  64'(m_axis_tdata), 64'd0);
        rrst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(DSIZE'(32'h60 + i));
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) expect_beat(DSIZE'(32'h60 + i), i == 3);
        expect_beats("mid_b_sb", 20);
        repeat (4) @(negedge rclk);
        check("no_extra_beats", 64'(got_n), 64'(got_rd));
`ifdef FIFO_RD_STREAM_STAT_EN
        check("end_pktcnt", 64'(pkt_cnt), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
